// File: rtl/metronome_display_multi.sv
// Metronome display: sequential double-dabble BCD conversion of a wide BPM counter,
// multiplexed seven-segment drive, retriggerable beat LED and two threshold LEDs.
module metronome_display_multi #(
  parameter int     NUM_DIGITS     = 4,
  parameter int     CNT_W          = 34,
  parameter int     HOLD_CYCLES    = 5000000,
  parameter int     REFRESH_CYCLES = 50000,
  parameter longint LOW_THRESH     = 600,
  parameter longint HIGH_THRESH    = 9999,
  parameter bit     ACTIVE_LOW     = 1'b1,
  parameter bit     BLANK_LEADING  = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_trigger,
  input  logic [CNT_W-1:0]      i_bpm_counter,
  output logic [2:0]            o_bpm_led,
  output logic [6:0]            o_ssi_segments,
  output logic [NUM_DIGITS-1:0] o_ssi_code,
  output logic                  o_conv_busy
);

  function automatic longint pow10(input int n);
    longint r;
    r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  localparam longint MAX_VAL = pow10(NUM_DIGITS) - 1;
  localparam int     SHIFT_W = $clog2(MAX_VAL + 1);
  localparam int     BCD_W   = 4 * NUM_DIGITS;
  localparam int     SCNT_W  = $clog2(SHIFT_W + 1);
  localparam int     DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int     REF_W   = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;
  localparam int     HOLD_W  = $clog2(HOLD_CYCLES + 1);

  localparam logic [6:0]            SEG_OFF  = {7{ACTIVE_LOW}};
  localparam logic [NUM_DIGITS-1:0] CODE_OFF = {NUM_DIGITS{ACTIVE_LOW}};

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_SHIFT = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  // Active-high segment pattern, bit 6 = g ... bit 0 = a; 10-15 blank.
  function automatic logic [6:0] seg_decode(input logic [3:0] n);
    logic [6:0] s;
    case (n)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      4'd9:    s = 7'h6F;
      default: s = 7'h00;
    endcase
    return s;
  endfunction

  state_t                  state_q, state_d;
  logic [SHIFT_W-1:0]      bin_q, bin_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d;
  logic [BCD_W-1:0]        bcd_adj;
  logic [SCNT_W-1:0]       scnt_q, scnt_d;
  logic [BCD_W-1:0]        display_q, display_d;
  logic [REF_W-1:0]        refresh_q, refresh_d;
  logic [DIG_W-1:0]        digit_q, digit_d;
  logic [HOLD_W-1:0]       hold_q, hold_d;
  logic [2:0]              led_q, led_d;
  logic [6:0]              seg_q, seg_d;
  logic [NUM_DIGITS-1:0]   code_q, code_d;
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [3:0]              cur_nib;
  logic                    cur_blank;
  logic                    higher_zero;
  logic [63:0]             cnt_ext;

  assign cnt_ext = 64'(i_bpm_counter);

  // Add-3 correction applied to every nibble before each shift.
  always_comb begin
    bcd_adj = bcd_q;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (bcd_q[i*4 +: 4] >= 4'd5) bcd_adj[i*4 +: 4] = bcd_q[i*4 +: 4] + 4'd3;
    end
  end

  always_comb begin
    state_d   = state_q;
    bin_d     = bin_q;
    bcd_d     = bcd_q;
    scnt_d    = scnt_q;
    display_d = display_q;
    case (state_q)
      S_IDLE: state_d = S_LOAD;
      S_LOAD: begin
        bin_d   = (cnt_ext > 64'(MAX_VAL)) ? SHIFT_W'(MAX_VAL) : SHIFT_W'(cnt_ext);
        bcd_d   = '0;
        scnt_d  = '0;
        state_d = S_SHIFT;
      end
      S_SHIFT: begin
        bcd_d  = {bcd_adj[BCD_W-2:0], bin_q[SHIFT_W-1]};
        bin_d  = bin_q << 1;
        scnt_d = scnt_q + SCNT_W'(1);
        if (scnt_q == SCNT_W'(SHIFT_W - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        display_d = bcd_q;
        state_d   = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    hold_d = hold_q;
    if (i_trigger)           hold_d = HOLD_W'(HOLD_CYCLES);
    else if (hold_q != '0)   hold_d = hold_q - HOLD_W'(1);
    led_d = {hold_d != '0, cnt_ext >= 64'(HIGH_THRESH), cnt_ext >= 64'(LOW_THRESH)};
  end

  always_comb begin
    refresh_d = refresh_q + REF_W'(1);
    digit_d   = digit_q;
    if (refresh_q == REF_W'(REFRESH_CYCLES - 1)) begin
      refresh_d = '0;
      digit_d   = (digit_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_q + DIG_W'(1);
    end
  end

  // A digit is blank when it and every more-significant digit are zero; digit 0 always shows.
  always_comb begin
    higher_zero = 1'b1;
    blank_mask  = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      higher_zero   = higher_zero & (display_q[i*4 +: 4] == 4'd0);
      blank_mask[i] = BLANK_LEADING && (i != 0) && higher_zero;
    end
  end

  always_comb begin
    cur_nib   = '0;
    cur_blank = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (digit_q == DIG_W'(i)) begin
        cur_nib   = display_q[i*4 +: 4];
        cur_blank = blank_mask[i];
      end
    end
    onehot = NUM_DIGITS'(1) << digit_q;
    code_d = ACTIVE_LOW ? ~onehot : onehot;
    if (cur_blank) seg_d = SEG_OFF;
    else           seg_d = ACTIVE_LOW ? ~seg_decode(cur_nib) : seg_decode(cur_nib);
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q   <= S_IDLE;
      bin_q     <= '0;
      bcd_q     <= '0;
      scnt_q    <= '0;
      display_q <= '0;
      refresh_q <= '0;
      digit_q   <= '0;
      hold_q    <= '0;
      led_q     <= '0;
      seg_q     <= SEG_OFF;
      code_q    <= CODE_OFF;
    end else begin
      state_q   <= state_d;
      bin_q     <= bin_d;
      bcd_q     <= bcd_d;
      scnt_q    <= scnt_d;
      display_q <= display_d;
      refresh_q <= refresh_d;
      digit_q   <= digit_d;
      hold_q    <= hold_d;
      led_q     <= led_d;
      seg_q     <= seg_d;
      code_q    <= code_d;
    end
  end

  assign o_bpm_led      = led_q;
  assign o_ssi_segments = seg_q;
  assign o_ssi_code     = code_q;
  assign o_conv_busy    = (state_q == S_LOAD) || (state_q == S_SHIFT);

endmodule
